// File: rtl/uart_recv_pkg.sv
// Shared UART receive definitions: default clocking, FSM state encoding, parity helper.
// The optional receive parity check is enabled with `define UART_RX_PARITY_EN.
package uart_recv_pkg;

   localparam int DEF_CLK_FREQ = 35_000_000;
   localparam int DEF_UART_BPS = 128_000;

   typedef enum logic [2:0] {
      RX_IDLE   = 3'd0,
      RX_START  = 3'd1,
      RX_DATA   = 3'd2,
      RX_PARITY = 3'd3,
      RX_STOP   = 3'd4
   } rx_state_t;

   // Even parity: the bit that makes the total number of ones even.
   function automatic logic even_parity(input logic [7:0] data);
      return ^data;
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Three-flop synchronizer for the asynchronous RX pin, with a falling-edge strobe.
module uart_rx_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic rxd,
   output logic rxd_s,
   output logic fall
);

   logic rxd_d0;
   logic rxd_d1;
   logic rxd_d2;

   // Flops reset high so an idle line never looks like a start edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rxd_d0 <= 1'b1;
         rxd_d1 <= 1'b1;
         rxd_d2 <= 1'b1;
      end else begin
         rxd_d0 <= rxd;
         rxd_d1 <= rxd_d0;
         rxd_d2 <= rxd_d1;
      end
   end

   assign rxd_s = rxd_d1;
   assign fall  = rxd_d2 & ~rxd_d1;

endmodule

// File: rtl/uart_recv.sv
// 8N1 UART receiver: centre-samples each bit and emits a byte plus a one-cycle strobe.
// Optional even-parity bit between data and stop when UART_RX_PARITY_EN is defined.
module uart_recv
   import uart_recv_pkg::*;
#(
   parameter int CLK_FREQ = DEF_CLK_FREQ,
   parameter int UART_BPS = DEF_UART_BPS
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic       uart_rxd,
   output logic [7:0] uart_data,
   output logic       uart_done,
   output logic       rx_busy,
   output logic       frame_err,
   output logic       parity_err
);

   localparam int BPS_CNT  = CLK_FREQ / UART_BPS;
   localparam int HALF_CNT = BPS_CNT / 2;
   localparam logic [15:0] BPS_LAST  = 16'(BPS_CNT - 1);
   localparam logic [15:0] HALF_LAST = 16'(HALF_CNT - 1);

   rx_state_t   state;
   logic [15:0] clk_cnt;
   logic [2:0]  bit_cnt;
   logic [7:0]  shift;
   logic        rxd_s;
   logic        fall;

   uart_rx_sync u_sync (
      .clk   (sys_clk),
      .rst_n (sys_rst_n),
      .rxd   (uart_rxd),
      .rxd_s (rxd_s),
      .fall  (fall)
   );

`ifdef UART_RX_PARITY_EN
   logic par_bad;
   logic par_pulse;
   assign parity_err = par_pulse;
`else
   assign parity_err = 1'b0;
`endif

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         state     <= RX_IDLE;
         clk_cnt   <= '0;
         bit_cnt   <= '0;
         shift     <= '0;
         uart_data <= '0;
         uart_done <= 1'b0;
         rx_busy   <= 1'b0;
         frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bad   <= 1'b0;
         par_pulse <= 1'b0;
`endif
      end else begin
         uart_done <= 1'b0;
         frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_pulse <= 1'b0;
`endif
         case (state)
            RX_IDLE: begin
               if (fall) begin
                  state   <= RX_START;
                  clk_cnt <= '0;
                  rx_busy <= 1'b1;
               end
            end
            RX_START: begin
               if (clk_cnt == HALF_LAST) begin
                  clk_cnt <= '0;
                  bit_cnt <= '0;
                  // A line that is high again at mid-start was only a glitch.
                  if (rxd_s) begin
                     state   <= RX_IDLE;
                     rx_busy <= 1'b0;
                  end else begin
                     state <= RX_DATA;
                  end
               end else begin
                  clk_cnt <= clk_cnt + 16'd1;
               end
            end
            RX_DATA: begin
               if (clk_cnt == BPS_LAST) begin
                  clk_cnt        <= '0;
                  shift[bit_cnt] <= rxd_s;
                  bit_cnt        <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                     state <= RX_PARITY;
`else
                     state <= RX_STOP;
`endif
                  end
               end else begin
                  clk_cnt <= clk_cnt + 16'd1;
               end
            end
`ifdef UART_RX_PARITY_EN
            RX_PARITY: begin
               if (clk_cnt == BPS_LAST) begin
                  clk_cnt <= '0;
                  par_bad <= (rxd_s != even_parity(shift));
                  state   <= RX_STOP;
               end else begin
                  clk_cnt <= clk_cnt + 16'd1;
               end
            end
`endif
            RX_STOP: begin
               // Decide at mid-stop so a back-to-back start edge is not missed.
               if (clk_cnt == BPS_LAST) begin
                  clk_cnt <= '0;
                  state   <= RX_IDLE;
                  rx_busy <= 1'b0;
                  if (rxd_s) begin
                     uart_data <= shift;
                     uart_done <= 1'b1;
                  end else begin
                     frame_err <= 1'b1;
                  end
`ifdef UART_RX_PARITY_EN
                  par_pulse <= par_bad;
`endif
               end else begin
                  clk_cnt <= clk_cnt + 16'd1;
               end
            end
            default: begin
               state   <= RX_IDLE;
               rx_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_recv.sv
// Directed bench for uart_recv: 8N1 frames, glitches, framing errors, back-to-back and reset abort.
module tb_uart_recv;

   localparam int BPS     = 35_000_000 / 128_000;
   localparam int HALF    = BPS / 2;
   localparam int LAT     = HALF + 9 * BPS + 3;

   logic       clk;
   logic       rst_n;
   logic       rxd;
   logic [7:0] uart_data;
   logic       uart_done;
   logic       rx_busy;
   logic       frame_err;
   logic       parity_err;

   int checks;
   int errors;
   int cyc;
   int done_cnt, ferr_cnt, perr_cnt, both_cnt, busy_cnt, width_err;
   int last_done_cyc;
   int fall_cyc;
   logic prev_done, prev_ferr, prev_perr;
   logic [7:0] got_q[$];

   uart_recv dut (
      .sys_clk    (clk),
      .sys_rst_n  (rst_n),
      .uart_rxd   (rxd),
      .uart_data  (uart_data),
      .uart_done  (uart_done),
      .rx_busy    (rx_busy),
      .frame_err  (frame_err),
      .parity_err (parity_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // Pulse monitor sampled on the falling edge.
   always @(negedge clk) begin
      if (uart_done) begin
         done_cnt++;
         last_done_cyc = cyc;
         got_q.push_back(uart_data);
      end
      if (frame_err) ferr_cnt++;
      if (parity_err) perr_cnt++;
      if (parity_err && uart_done) both_cnt++;
      if (rx_busy) busy_cnt++;
      if ((uart_done && prev_done) || (frame_err && prev_ferr) ||
          (parity_err && prev_perr) || (uart_done && frame_err))
         width_err++;
      prev_done = uart_done;
      prev_ferr = frame_err;
      prev_perr = parity_err;
   end

   task automatic drive_bit(input logic b);
      rxd = b;
      repeat (BPS) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
      @(negedge clk);
      fall_cyc = cyc;
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
      drive_bit(par);
`else
      if (par) begin end
`endif
      drive_bit(stop);
      rxd = 1'b1;
   endtask

   task automatic idle(input int n);
      rxd = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      rxd   = 1'b1;
      repeat (4) @(posedge clk);
      @(negedge clk);
      checks++;
      if (uart_data !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", uart_data); end
      checks++;
      if (uart_done !== 1'b0 || frame_err !== 1'b0) begin
         errors++; $display("FAIL reset_pulses done=%b ferr=%b exp=0", uart_done, frame_err);
      end
      checks++;
      if (rx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", rx_busy); end
      checks++;
      if (parity_err !== 1'b0) begin errors++; $display("FAIL reset_parity got=%b exp=0", parity_err); end
      rst_n = 1'b1;
      idle(10);
   endtask

   task automatic test_basic;
      int d0, f0, w0, lat;
      d0 = done_cnt; f0 = ferr_cnt; w0 = width_err;
      send_frame(8'h55, 1'b0, 1'b1);
      idle(20);
      checks++;
      if (done_cnt - d0 != 1) begin errors++; $display("FAIL basic_done_count got=%0d exp=1", done_cnt - d0); end
      checks++;
      if (uart_data !== 8'h55) begin errors++; $display("FAIL basic_data got=%h exp=55", uart_data); end
      lat = last_done_cyc - fall_cyc;
      checks++;
      if (lat < LAT - 1 || lat > LAT + 1) begin
         errors++; $display("FAIL basic_latency got=%0d exp=%0d+/-1", lat, LAT);
      end
      checks++;
      if (ferr_cnt != f0) begin errors++; $display("FAIL basic_ferr got=%0d exp=0", ferr_cnt - f0); end
      checks++;
      if (width_err != w0) begin errors++; $display("FAIL basic_width got=%0d exp=0", width_err - w0); end
   endtask

   task automatic test_glitch;
      int d0, f0, b0;
      d0 = done_cnt; f0 = ferr_cnt; b0 = busy_cnt;
      @(negedge clk);
      rxd = 1'b0;
      repeat (60) @(negedge clk);
      idle(300);
      checks++;
      if (busy_cnt == b0) begin errors++; $display("FAIL glitch_busy_seen got=0 exp>0"); end
      checks++;
      if (rx_busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_end got=%b exp=0", rx_busy); end
      checks++;
      if (done_cnt != d0 || ferr_cnt != f0) begin
         errors++; $display("FAIL glitch_pulses done=%0d ferr=%0d exp=0", done_cnt - d0, ferr_cnt - f0);
      end
   endtask

   task automatic test_frame_err;
      int d0, f0, w0;
      send_frame(8'h11, 1'b0, 1'b1);
      idle(20);
      d0 = done_cnt; f0 = ferr_cnt; w0 = width_err;
      send_frame(8'hA3, 1'b0, 1'b0);
      idle(20);
      checks++;
      if (ferr_cnt - f0 != 1) begin errors++; $display("FAIL ferr_count got=%0d exp=1", ferr_cnt - f0); end
      checks++;
      if (uart_data !== 8'h11) begin errors++; $display("FAIL ferr_data got=%h exp=11", uart_data); end
      checks++;
      if (done_cnt != d0 || width_err != w0) begin
         errors++; $display("FAIL ferr_no_done done=%0d width=%0d exp=0", done_cnt - d0, width_err - w0);
      end
   endtask

   task automatic test_back_to_back;
      int n, d0;
      n = got_q.size(); d0 = done_cnt;
      send_frame(8'h00, 1'b0, 1'b1);
      send_frame(8'hFF, 1'b0, 1'b1);
      idle(20);
      checks++;
      if (done_cnt - d0 != 2) begin errors++; $display("FAIL b2b_count got=%0d exp=2", done_cnt - d0); end
      else begin
         checks++;
         if (got_q[n] !== 8'h00) begin errors++; $display("FAIL b2b_first got=%h exp=00", got_q[n]); end
         checks++;
         if (got_q[n+1] !== 8'hFF) begin errors++; $display("FAIL b2b_second got=%h exp=FF", got_q[n+1]); end
      end
   endtask

   task automatic test_reset_mid_frame;
      logic [7:0] d;
      int d0, f0;
      d = 8'h96;
      d0 = done_cnt; f0 = ferr_cnt;
      @(negedge clk);
      drive_bit(1'b0);
      for (int i = 0; i < 5; i++) drive_bit(d[i]);
      rst_n = 1'b0;
      rxd   = 1'b1;
      repeat (4) @(negedge clk);
      checks++;
      if (uart_data !== 8'h00) begin errors++; $display("FAIL midrst_data got=%h exp=00", uart_data); end
      checks++;
      if (rx_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", rx_busy); end
      rst_n = 1'b1;
      idle(3 * BPS);
      checks++;
      if (done_cnt != d0 || ferr_cnt != f0) begin
         errors++; $display("FAIL midrst_pulses done=%0d ferr=%0d exp=0", done_cnt - d0, ferr_cnt - f0);
      end
      send_frame(8'h3C, 1'b0, 1'b1);
      idle(20);
      checks++;
      if (done_cnt - d0 != 1 || uart_data !== 8'h3C) begin
         errors++; $display("FAIL midrst_recover got=%h cnt=%0d exp=3c cnt=1", uart_data, done_cnt - d0);
      end
   endtask

`ifdef UART_RX_PARITY_EN
   task automatic test_parity;
      int d0, p0, b0;
      d0 = done_cnt; p0 = perr_cnt; b0 = both_cnt;
      send_frame(8'h07, 1'b1, 1'b1);
      idle(20);
      checks++;
      if (done_cnt - d0 != 1 || uart_data !== 8'h07 || perr_cnt != p0) begin
         errors++; $display("FAIL parity_good data=%h done=%0d perr=%0d exp=07/1/0", uart_data, done_cnt - d0, perr_cnt - p0);
      end
      send_frame(8'h07, 1'b0, 1'b1);
      idle(20);
      checks++;
      if (done_cnt - d0 != 2 || perr_cnt - p0 != 1 || both_cnt - b0 != 1) begin
         errors++; $display("FAIL parity_bad done=%0d perr=%0d same=%0d exp=2/1/1", done_cnt - d0, perr_cnt - p0, both_cnt - b0);
      end
   endtask
`else
   task automatic test_parity;
      checks++;
      if (perr_cnt != 0) begin errors++; $display("FAIL parity_tied got=%0d exp=0", perr_cnt); end
   endtask
`endif

   initial begin
      checks = 0; errors = 0; cyc = 0;
      done_cnt = 0; ferr_cnt = 0; perr_cnt = 0; both_cnt = 0; busy_cnt = 0; width_err = 0;
      last_done_cyc = 0; fall_cyc = 0;
      prev_done = 1'b0; prev_ferr = 1'b0; prev_perr = 1'b0;
      rst_n = 1'b0;
      rxd   = 1'b1;
      test_reset;
      test_basic;
      test_glitch;
      test_frame_err;
      test_back_to_back;
      test_reset_mid_frame;
      test_parity;
      checks++;
      if (width_err != 0) begin errors++; $display("FAIL pulse_width got=%0d exp=0", width_err); end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
